// File: rtl/shifter_settle_sequencer.sv
// -----------------------------------------------------------------------------
// shifter_settle_sequencer
//
// Sequential wrapper around a 4-bit combinational rotate-left barrel shifter.
// It accepts a word and a total rotate amount over a valid/ready handshake.
// It then walks the shifter through one or more passes of at most 3 positions.
// In each pass, sh_a/sh_s are held stable for SETTLE_CYCLES clocks before sh_o
// is captured. Each captured value becomes the data for the next pass. After
// the last pass, the result is presented on out_data until the consumer takes it.
//
// Ports:
//   clk, rst_n          clock (rising edge) / asynchronous active-low reset
//   in_valid, in_ready  request handshake (in_ready high only while idle)
//   in_data, in_amt     word to rotate, total rotate-left amount
//   sh_a, sh_s          data / select driven to the shifter (registered)
//   sh_o                shifter output, sampled at the end of each pass
//   out_valid,out_ready result handshake
//   out_data            final rotated word (registered, held until accepted)
// -----------------------------------------------------------------------------
module shifter_settle_sequencer #(
   parameter int SETTLE_CYCLES = 8,
   parameter int AMT_W         = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_data,
   input  logic [AMT_W-1:0] in_amt,
   output logic [3:0]       sh_a,
   output logic [1:0]       sh_s,
   input  logic [3:0]       sh_o,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       out_data
);

   // A counter of at least one bit, so that SETTLE_CYCLES=1 still elaborates.
   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      OUT    = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       sh_a_q, sh_a_d;
   logic [1:0]       sh_s_q, sh_s_d;
   logic [3:0]       out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [AMT_W-1:0] rem_q, rem_d;

   logic [1:0]       in_step;
   logic [1:0]       rem_step;

   // One pass can rotate by at most 3 positions (the shifter's select range).
   function automatic logic [1:0] step_of(input logic [AMT_W-1:0] amt);
      if (amt > AMT_W'(3)) begin
         return 2'd3;
      end
      return amt[1:0];
   endfunction

   assign in_step  = step_of(in_amt);
   assign rem_step = step_of(rem_q);

   always_comb begin
      state_d     = state_q;
      sh_a_d      = sh_a_q;
      sh_s_d      = sh_s_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      cnt_d       = cnt_q;
      rem_d       = rem_q;

      case (state_q)
         IDLE: begin
            // in_ready is implied by being in IDLE.
            if (in_valid) begin
               sh_a_d  = in_data;
               sh_s_d  = in_step;
               rem_d   = in_amt - AMT_W'(in_step);
               cnt_d   = CNT_LOAD;
               state_d = SETTLE;
            end
         end

         SETTLE: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (rem_q == '0) begin
               out_data_d  = sh_o;
               out_valid_d = 1'b1;
               state_d     = OUT;
            end else begin
               // Feed the settled result back for another pass.
               sh_a_d = sh_o;
               sh_s_d = rem_step;
               rem_d  = rem_q - AMT_W'(rem_step);
               cnt_d  = CNT_LOAD;
            end
         end

         OUT: begin
            // No bypass to IDLE acceptance: a new request waits one more edge.
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sh_a_q      <= '0;
         sh_s_q      <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         cnt_q       <= '0;
         rem_q       <= '0;
      end else begin
         state_q     <= state_d;
         sh_a_q      <= sh_a_d;
         sh_s_q      <= sh_s_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         cnt_q       <= cnt_d;
         rem_q       <= rem_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign sh_a      = sh_a_q;
   assign sh_s      = sh_s_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_shifter_settle_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for shifter_settle_sequencer. The bench models the shifter itself.
// A transaction-level model predicts the outputs on every cycle from the
// accepted word/amount and the time elapsed since the accept edge. Directed
// transactions also carry hand-computed results and latencies.
// -----------------------------------------------------------------------------
module tb_shifter_settle_sequencer;

   localparam int S  = 8;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    in_data;
   logic [AW-1:0] in_amt;
   logic [3:0]    sh_a;
   logic [1:0]    sh_s;
   logic [3:0]    sh_o;
   logic          out_valid;
   logic          out_ready;
   logic [3:0]    out_data;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   shifter_settle_sequencer #(.SETTLE_CYCLES(S), .AMT_W(AW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_amt   (in_amt),
      .sh_a     (sh_a),
      .sh_s     (sh_s),
      .sh_o     (sh_o),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data)
   );

   function automatic logic [3:0] rotl(input logic [3:0] x, input int n);
      logic [7:0] w;
      w = {x, x} << (n % 4);
      return w[7:4];
   endfunction

   // Ideal combinational shifter.
   assign sh_o = rotl(sh_a, int'(sh_s));

   function automatic int passes(input int a);
      return (a == 0) ? 1 : (a + 2) / 3;
   endfunction

   // ---------------- transaction-level model ----------------
   // m_mode: 0 idle, 1 busy (m_t edges since accept), 2 result held
   int         m_mode;
   int         m_t;
   logic [3:0] m_data;
   int         m_amt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode <= 0;
         m_t    <= 0;
         m_data <= 4'h0;
         m_amt  <= 0;
      end else begin
         case (m_mode)
            0: if (in_valid) begin
                  m_mode <= 1;
                  m_t    <= 0;
                  m_data <= in_data;
                  m_amt  <= int'(in_amt);
               end
            1: begin
                  if (m_t + 1 == passes(m_amt) * S) m_mode <= 2;
                  m_t <= m_t + 1;
               end
            default: if (out_ready) m_mode <= 0;
         endcase
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic send(input logic [3:0] d, input logic [AW-1:0] a);
      logic r;
      logic acc;
      int   n;
      in_valid = 1'b1;
      in_data  = d;
      in_amt   = a;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 200) begin
         r = in_ready;
         @(posedge clk);
         #2;
         n++;
         if (r) acc = 1'b1;
      end
      chk("accept", {7'd0, acc}, 8'd1);
      in_valid = 1'b0;
      // Later input changes must be ignored by the block.
      in_data  = ~d;
      in_amt   = '1;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 1000) begin
         @(posedge clk);
         #2;
         lat++;
      end
      chk("out_valid_seen", {7'd0, out_valid}, 8'd1);
   endtask

   task automatic run_txn(input logic [3:0] d, input logic [AW-1:0] a,
                          input logic [3:0] exp_d, input int exp_lat);
      int         lat;
      logic [3:0] got;
      send(d, a);
      wait_valid(lat);
      got = out_data;
      chk("latency", 8'(lat), 8'(exp_lat));
      chk("result", {4'd0, got}, {4'd0, exp_d});
      out_ready = 1'b1;
      @(posedge clk);
      #2;
      out_ready = 1'b0;
      $display("[TB] txn data=%b amt=%0d -> out=%b latency=%0d", d, a, got, lat);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int         lat;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_data   = 4'h0;
      in_amt    = '0;
      rst_n     = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;

      // Per-cycle compare against the model, sampled on the falling edge.
      fork
         forever begin
            int p;
            int step;
            @(negedge clk);
            if (m_mode == 1) p = m_t / S;
            else             p = passes(m_amt) - 1;
            step = m_amt - 3 * p;
            if (step > 3) step = 3;
            chk("sh_a", {4'd0, sh_a}, {4'd0, rotl(m_data, 3 * p)});
            chk("sh_s", {6'd0, sh_s}, 8'(step));
            chk("in_ready", {7'd0, in_ready}, {7'd0, (m_mode == 0)});
            chk("out_valid", {7'd0, out_valid}, {7'd0, (m_mode == 2)});
            if (m_mode == 2)
               chk("out_data", {4'd0, out_data}, {4'd0, rotl(m_data, m_amt % 4)});
         end
      join_none

      // Reset state.
      chk("rst_in_ready", {7'd0, in_ready}, 8'd1);
      chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
      chk("rst_sh_a", {4'd0, sh_a}, 8'd0);
      chk("rst_sh_s", {6'd0, sh_s}, 8'd0);

      // Directed transactions with hand-computed results.
      run_txn(4'b0001, 4'd1,  4'b0010, 8);
      run_txn(4'b1011, 4'd0,  4'b1011, 8);
      run_txn(4'b0001, 4'd5,  4'b0010, 16);
      run_txn(4'b0001, 4'd15, 4'b1000, 40);
      run_txn(4'b0110, 4'd6,  4'b1001, 16);

      // Backpressure: result must be held while a new request waits.
      send(4'b0110, 4'd2);
      wait_valid(lat);
      chk("bp_latency", 8'(lat), 8'd8);
      in_valid = 1'b1;
      in_data  = 4'b0011;
      in_amt   = 4'd1;
      repeat (5) begin
         @(posedge clk);
         #2;
         chk("bp_out_valid", {7'd0, out_valid}, 8'd1);
         chk("bp_out_data", {4'd0, out_data}, 8'b0000_1001);
         chk("bp_in_ready", {7'd0, in_ready}, 8'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #2;
      out_ready = 1'b0;
      chk("bp_drop_valid", {7'd0, out_valid}, 8'd0);
      chk("bp_idle_ready", {7'd0, in_ready}, 8'd1);
      @(posedge clk);
      #2;
      in_valid = 1'b0;
      chk("bp_accepted", {7'd0, in_ready}, 8'd0);
      chk("bp_sh_a", {4'd0, sh_a}, 8'b0000_0011);
      chk("bp_sh_s", {6'd0, sh_s}, 8'd1);
      wait_valid(lat);
      chk("bp2_latency", 8'(lat), 8'd8);
      chk("bp2_result", {4'd0, out_data}, 8'b0000_0110);
      out_ready = 1'b1;
      @(posedge clk);
      #2;
      out_ready = 1'b0;
      $display("[TB] txn backpressure pair done, second out=%b", 4'b0110);

      // Asynchronous reset during pass 2 of a 3-pass transaction.
      send(4'b0001, 4'd9);
      repeat (S + 3) begin
         @(posedge clk);
         #2;
      end
      chk("pre_rst_sh_a", {4'd0, sh_a}, 8'b0000_1000);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_sh_a", {4'd0, sh_a}, 8'd0);
      chk("arst_sh_s", {6'd0, sh_s}, 8'd0);
      chk("arst_out_valid", {7'd0, out_valid}, 8'd0);
      chk("arst_out_data", {4'd0, out_data}, 8'd0);
      chk("arst_in_ready", {7'd0, in_ready}, 8'd1);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      repeat (30) begin
         @(posedge clk);
         #2;
         chk("post_rst_no_valid", {7'd0, out_valid}, 8'd0);
      end
      $display("[TB] txn data=0001 amt=9 aborted by reset");

      run_txn(4'b1100, 4'd3, 4'b0110, 8);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/shifter_settle_sequencer.md
Name: shifter_settle_sequencer

Overview:
- Sequential front/back end for the 4-bit combinational barrel shifter. It sits directly around that shifter.
- It accepts a 4-bit word and a rotate amount over a valid/ready handshake. It drives the shifter's data and select inputs and holds them stable for a programmable settle time that covers the shifter's worst-case propagation delay.
- It then captures the shifter output into a register.
- Amounts larger than 3 are decomposed into successive passes of at most 3. Each captured result is fed back as the next pass's data, so the shifter is exercised in multiple settle windows per transaction.

Parameters:
- SETTLE_CYCLES, 8, clock cycles each pass holds sh_a/sh_s stable before capturing sh_o. Legal range ≥1.
- AMT_W, 4, width of the requested rotate amount (0..2^AMT_W-1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request; high only in IDLE.
- in_data  in  4  word to rotate.
- in_amt  in  AMT_W  total rotate-left amount.
- sh_a  out  4  data to shifter (A0..A3 = bits 0..3).
- sh_s  out  2  select to shifter (S0 = bit 0, S1 = bit 1).
- sh_o  in  4  shifter output (SHO0..SHO3).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  4  final rotated word.

Behaviour:
- Shifter contract: sh_o[i] = sh_a[(i - sh_s) mod 4], i.e. rotate-left by sh_s. The block does not check sh_o; it only samples it.
- Reset (async, takes effect immediately, any state): state=IDLE, sh_a=0, sh_s=0, out_data=0, out_valid=0, settle counter=0, remaining=0; in_ready=1 after reset. An in-flight word is dropped; no output is produced for it.
- in_ready = (state==IDLE), registered-state decode, no combinational path from in_valid or out_ready.
- States: IDLE, SETTLE, OUT.
- IDLE: on an edge with in_valid&&in_ready:
  - sh_a<=in_data; step=min(in_amt,3); sh_s<=step; remaining<=in_amt-step; cnt<=SETTLE_CYCLES-1; go SETTLE.
  - in_amt=0 still performs one pass with sh_s=0.
- SETTLE: sh_a and sh_s must not change.
  - cnt>0: cnt decrements.
  - cnt==0 and remaining==0: out_data<=sh_o; out_valid<=1; go OUT.
  - cnt==0 and remaining>0: sh_a<=sh_o; step=min(remaining,3); sh_s<=step; remaining-=step; cnt<=SETTLE_CYCLES-1; stay SETTLE.
- OUT:
  - out_valid=1 and out_data held stable until out_ready is sampled high.
  - On that edge: out_valid<=0, go IDLE.
  - No bypass: a new request cannot be accepted in the same cycle as the output handshake.
- sh_a/sh_s hold their last values in OUT and IDLE.
- Passes P = max(1, ceil(in_amt/3)).
- Latency: request accepted at edge k → out_valid high after edge k+P*SETTLE_CYCLES.
- Minimum request-to-request spacing: P*SETTLE_CYCLES+2 cycles.
- Result equals in_data rotated left by (in_amt mod 4).
- SETTLE_CYCLES=1: each pass captures on the first edge after entering or reloading SETTLE.
- Input fields are sampled only on the accept edge; later changes to in_data/in_amt are ignored.

Test Plan:
- Reset, then in_data=4'b0001, in_amt=1, SETTLE_CYCLES=8 → sh_s=1 for 8 cycles with sh_a=0001 stable; out_valid rises 8 edges after accept; out_data=4'b0010.
- in_data=4'b1011, in_amt=0 → one pass, sh_s=0; out_data=4'b1011 after 8 cycles.
- in_data=4'b0001, in_amt=5 → sh_s sequence 3 then 2; sh_a becomes 1000 in pass 2; out_data=4'b0010 at 16 cycles.
- in_data=4'b0001, in_amt=15 → 5 passes of 3; out_data=4'b1000 at 40 cycles.
- Backpressure: hold out_ready=0 for 5 cycles while in_valid=1 → out_valid and out_data stable, in_ready=0, no accept. Then raise out_ready → out_valid falls next edge; the new request is accepted one edge later.
- Assert rst_n low mid-SETTLE (amt=9, pass 2) → outputs go to reset values immediately, with no clock edge needed. After release, in_ready=1 and no stale out_valid appears.
